divider_feeder: RTL and testbench

DIVIDER_FEEDER -- requirements
Module: divider_feeder

---
 rtl/divider_feeder.sv | 175 +++++++++++++++++
 tb/tb_divider_feeder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_feeder.sv
// Operand FIFO plus Start/Done/Ack sequencer in front of an iterative 4-bit divider.
// Build macro DIVFEED_ZERO_CHECK_EN: zero-divisor pairs are answered locally (ResErr=1).
module divider_feeder #(
   parameter int DEPTH = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Load,
   input  logic [3:0] LoadX,
   input  logic [3:0] LoadY,
   output logic       Full,
   output logic       Empty,
   output logic       Overflow,
   output logic [3:0] Xin,
   output logic [3:0] Yin,
   output logic       Start,
   output logic       Ack,
   input  logic       Done,
   input  logic [3:0] Quotient,
   input  logic [3:0] Remainder,
   output logic       ResValid,
   output logic       ResErr,
   output logic [3:0] ResQ,
   output logic [3:0] ResR,
   input  logic       ResRd,
   output logic       Busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK_S} state_t;

   logic [7:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          overflow_reg;

   state_t        state_reg;
   logic          start_reg;
   logic          ack_reg;
   logic [3:0]    xin_reg;
   logic [3:0]    yin_reg;
   logic          res_valid_reg;
   logic          res_err_reg;
   logic [3:0]    res_q_reg;
   logic [3:0]    res_r_reg;

   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [7:0]    head;
   logic [3:0]    head_x;
   logic [3:0]    head_y;
   logic          zero_div;

   assign fifo_full  = (count_reg == CW'(DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign head       = fifo_mem[rd_ptr_reg];
   assign head_x     = head[7:4];
   assign head_y     = head[3:0];

   // Loads arriving while full are dropped even if a pop happens in the same cycle.
   assign push = Load && !fifo_full;
   // Pop decision uses the registered count, so a fresh entry always waits one cycle.
   assign pop  = (state_reg == IDLE) && !fifo_empty && (!res_valid_reg || ResRd);

`ifdef DIVFEED_ZERO_CHECK_EN
   assign zero_div = (head_y == 4'd0);
`else
   assign zero_div = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {LoadX, LoadY};
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
         if (Load && fifo_full) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg     <= IDLE;
         start_reg     <= 1'b0;
         ack_reg       <= 1'b0;
         xin_reg       <= 4'd0;
         yin_reg       <= 4'd0;
         res_valid_reg <= 1'b0;
         res_err_reg   <= 1'b0;
         res_q_reg     <= 4'd0;
         res_r_reg     <= 4'd0;
      end else begin
         start_reg <= 1'b0;
         ack_reg   <= 1'b0;
         // A capture later in this block overrides the read-clear, so new results win.
         if (ResRd && res_valid_reg) begin
            res_valid_reg <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  if (zero_div) begin
                     res_q_reg     <= 4'hF;
                     res_r_reg     <= head_x;
                     res_err_reg   <= 1'b1;
                     res_valid_reg <= 1'b1;
                  end else begin
                     xin_reg   <= head_x;
                     yin_reg   <= head_y;
                     start_reg <= 1'b1;
                     state_reg <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state_reg <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (Done) begin
                  res_q_reg     <= Quotient;
                  res_r_reg     <= Remainder;
                  res_err_reg   <= 1'b0;
                  res_valid_reg <= 1'b1;
                  ack_reg       <= 1'b1;
                  state_reg     <= ACK_S;
               end
            end
            ACK_S: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign Full     = fifo_full;
   assign Empty    = fifo_empty;
   assign Overflow = overflow_reg;
   assign Xin      = xin_reg;
   assign Yin      = yin_reg;
   assign Start    = start_reg;
   assign Ack      = ack_reg;
   assign ResValid = res_valid_reg;
   assign ResErr   = res_err_reg;
   assign ResQ     = res_q_reg;
   assign ResR     = res_r_reg;
   assign Busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_divider_feeder.sv
// Bench for divider_feeder: repeated-subtraction divider stand-in, schedule-based model, directed tests.
module tb_divider_feeder;
   localparam int DEPTH = 4;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Load = 1'b0;
   logic [3:0] LoadX = 4'd0;
   logic [3:0] LoadY = 4'd0;
   logic       ResRd = 1'b0;
   logic       Full, Empty, Overflow, Start, Ack, ResValid, ResErr, Busy;
   logic [3:0] Xin, Yin, ResQ, ResR;
   logic       Done;
   logic [3:0] Quotient, Remainder;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_start = 0;
   int n_ack = 0;

   always #5 Clk = ~Clk;

   divider_feeder #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .LoadX(LoadX), .LoadY(LoadY),
      .Full(Full), .Empty(Empty), .Overflow(Overflow), .Xin(Xin), .Yin(Yin),
      .Start(Start), .Ack(Ack), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
      .ResValid(ResValid), .ResErr(ResErr), .ResQ(ResQ), .ResR(ResR),
      .ResRd(ResRd), .Busy(Busy)
   );

   // Divider stand-in: INIT -> COMPUTE (one subtraction per cycle) -> DONE until Ack.
   int         d_st;
   logic [3:0] d_x, d_y, d_q;
   always @(posedge Clk) begin
      if (Reset) begin
         d_st <= 0; d_x <= 4'd0; d_y <= 4'd0; d_q <= 4'd0;
      end else begin
         case (d_st)
            0: if (Start) begin d_x <= Xin; d_y <= Yin; d_q <= 4'd0; d_st <= 1; end
            1: if (d_x >= d_y) begin d_x <= d_x - d_y; d_q <= d_q + 4'd1; end
               else d_st <= 2;
            default: if (Ack) d_st <= 0;
         endcase
      end
   end
   assign Done      = (d_st == 2);
   assign Quotient  = d_q;
   assign Remainder = d_x;

   // Model: a queue of pairs plus a result slot; an issued job is a schedule measured
   // from its pop edge (Start at t=0, capture and Ack at t=3+X/Y, idle again at t=4+X/Y).
   typedef struct packed {logic [3:0] x; logic [3:0] y;} pair_t;
   pair_t      mq[$];
   bit         m_ovf = 0, m_busy = 0, m_rv = 0, m_err = 0;
   logic [3:0] m_rq = 0, m_rr = 0, m_xin = 0, m_yin = 0;
   int         m_t = 0, m_fin = 0;

   always @(posedge Clk) begin : model
      pair_t h;
      int    sz;
      bit    pop_now;
      sz = mq.size();
      if (Reset) begin
         mq.delete();
         m_ovf = 0; m_busy = 0; m_rv = 0; m_err = 0;
         m_rq = 0; m_rr = 0; m_xin = 0; m_yin = 0; m_t = 0; m_fin = 0;
      end else begin
         pop_now = !m_busy && sz != 0 && (!m_rv || ResRd);
         if (Load && sz == DEPTH) m_ovf = 1;
         if (ResRd) m_rv = 0;
         if (m_busy) begin
            m_t++;
            if (m_t == m_fin) begin
               m_rv = 1; m_err = 0; m_rq = m_xin / m_yin; m_rr = m_xin % m_yin;
            end
            if (m_t == m_fin + 1) m_busy = 0;
         end
         if (pop_now) begin
            h = mq.pop_front();
`ifdef DIVFEED_ZERO_CHECK_EN
            if (h.y == 4'd0) begin
               m_rv = 1; m_rq = 4'hF; m_rr = h.x; m_err = 1;
            end else begin
`else
            begin
`endif
               m_busy = 1; m_t = 0; m_xin = h.x; m_yin = h.y;
               m_fin = (h.y == 4'd0) ? (1 << 30) : 3 + int'(h.x / h.y);
            end
         end
         if (Load && sz < DEPTH) mq.push_back({LoadX, LoadY});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge Clk) cyc++;

   always begin
      @(posedge Clk);
      #1;
      if (Start === 1'b1) n_start++;
      if (Ack === 1'b1) n_ack++;
      chk("Empty", Empty, mq.size() == 0);
      chk("Full", Full, mq.size() == DEPTH);
      chk("Overflow", Overflow, m_ovf);
      chk("Xin", Xin, m_xin);
      chk("Yin", Yin, m_yin);
      chk("Start", Start, m_busy && m_t == 0);
      chk("Ack", Ack, m_busy && m_t == m_fin);
      chk("Busy", Busy, m_busy);
      chk("ResValid", ResValid, m_rv);
      chk("ResErr", ResErr, m_err);
      chk("ResQ", ResQ, m_rq);
      chk("ResR", ResR, m_rr);
   end

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1; Load = 1'b0; ResRd = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic do_load(input logic [3:0] x, input logic [3:0] y, output int edge_no);
      Load = 1'b1; LoadX = x; LoadY = y;
      @(negedge Clk);
      Load = 1'b0;
      edge_no = cyc;
   endtask

   task automatic wait_valid(input string name, input int budget, output int edge_no);
      for (int i = 0; i < budget && ResValid !== 1'b1; i++) @(negedge Clk);
      if (ResValid !== 1'b1) chk({name, "_timeout"}, 0, 1);
      edge_no = cyc;
   endtask

   task automatic get_result(input string name, output logic [3:0] q, output logic [3:0] r);
      int e;
      wait_valid(name, 60, e);
      q = ResQ; r = ResR;
      ResRd = 1'b1;
      @(negedge Clk);
      ResRd = 1'b0;
   endtask

   logic [3:0] tx [6] = '{4'd13, 4'd8, 4'd9, 4'd15, 4'd6, 4'd7};
   logic [3:0] ty [6] = '{4'd4,  4'd2, 4'd3, 4'd5,  4'd3, 4'd7};
   logic [3:0] eq [5] = '{4'd3, 4'd4, 4'd3, 4'd3, 4'd2};
   logic [3:0] er [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};

   initial begin
      int e, r;
      logic [3:0] q, rm;
      repeat (3) @(negedge Clk);
      chk("rst_Empty", Empty, 1);
      chk("rst_Full", Full, 0);
      chk("rst_Busy", Busy, 0);
      chk("rst_ResValid", ResValid, 0);
      chk("rst_Xin", Xin, 0);
      Reset = 1'b0;
      @(negedge Clk);

      // 13/4 -> 3 r 1, seven edges after the load edge
      n_start = 0; n_ack = 0;
      do_load(4'd13, 4'd4, e);
      wait_valid("t13_4", 40, r);
      chk("t13_4_latency", r - e, 7);
      chk("t13_4_q", ResQ, 3);
      chk("t13_4_r", ResR, 1);
      repeat (3) @(negedge Clk);
      chk("t13_4_starts", n_start, 1);
      chk("t13_4_acks", n_ack, 1);
      ResRd = 1'b1; @(negedge Clk); ResRd = 1'b0;
      repeat (3) @(negedge Clk);

      // 3/7 -> 0 r 3, four edges after the load edge
      do_load(4'd3, 4'd7, e);
      wait_valid("t3_7", 40, r);
      chk("t3_7_latency", r - e, 4);
      chk("t3_7_q", ResQ, 0);
      chk("t3_7_r", ResR, 3);
      ResRd = 1'b1; @(negedge Clk); ResRd = 1'b0;
      repeat (4) @(negedge Clk);

      // Back-to-back loads with the slot never read: the head is popped one cycle in,
      // so the fifth load fills the FIFO and the sixth is dropped.
      do_reset();
      n_start = 0;
      for (int i = 0; i < 6; i++) begin
         Load = 1'b1; LoadX = tx[i]; LoadY = ty[i];
         @(negedge Clk);
         if (i == 4) chk("burst_full_after_5", Full, 1);
      end
      Load = 1'b0;
      chk("burst_overflow", Overflow, 1);
      repeat (15) @(negedge Clk);
      chk("burst_held_valid", ResValid, 1);
      chk("burst_held_q", ResQ, 3);
      chk("burst_one_start", n_start, 1);
      chk("burst_still_full", Full, 1);
      for (int i = 0; i < 5; i++) begin
         get_result("burst_drain", q, rm);
         chk("burst_q", q, eq[i]);
         chk("burst_r", rm, er[i]);
      end
      repeat (6) @(negedge Clk);
      chk("burst_empty_end", Empty, 1);

      // Zero divisor
      do_reset();
      n_start = 0;
      do_load(4'd9, 4'd0, e);
      repeat (8) @(negedge Clk);
`ifdef DIVFEED_ZERO_CHECK_EN
      chk("zero_valid", ResValid, 1);
      chk("zero_q", ResQ, 4'hF);
      chk("zero_r", ResR, 9);
      chk("zero_err", ResErr, 1);
      chk("zero_no_start", n_start, 0);
      chk("zero_idle", Busy, 0);
`else
      chk("zero_start", n_start, 1);
      chk("zero_busy", Busy, 1);
      chk("zero_err", ResErr, 0);
`endif

      // Reset three cycles after Start aborts 15/1
      do_reset();
      do_load(4'd15, 4'd1, e);
      for (int i = 0; i < 10 && Start !== 1'b1; i++) @(negedge Clk);
      chk("abort_saw_start", Start, 1);
      repeat (3) @(negedge Clk);
      chk("abort_busy_before", Busy, 1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      n_ack = 0;
      repeat (25) @(negedge Clk);
      chk("abort_no_ack", n_ack, 0);
      chk("abort_empty", Empty, 1);
      chk("abort_no_result", ResValid, 0);
      chk("abort_idle", Busy, 0);

      // Two queued pairs read out in order
      do_reset();
      do_load(4'd8, 4'd2, e);
      do_load(4'd9, 4'd3, e);
      get_result("pair1", q, rm);
      chk("pair1_q", q, 4);
      chk("pair1_r", rm, 0);
      get_result("pair2", q, rm);
      chk("pair2_q", q, 3);
      chk("pair2_r", rm, 0);
      repeat (6) @(negedge Clk);
      chk("pairs_empty", Empty, 1);
      chk("pairs_idle", Busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end
endmodule
